// File: rtl/universal_shift_register_pkg.sv
// ============================================================================
// Module      : usr_pkg
// Description : Shared definitions for the universal shift register:
//               mode encodings used by the datapath decode and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    // Operating mode encodings
    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

endpackage : usr_pkg

`default_nettype wire

// File: rtl/universal_shift_register_if.sv
// ============================================================================
// Module      : universal_shift_register_if
// Description : Control/data bundle of the universal shift register.
//               master = driver of mode/data, slave = the register itself.
//               Optional macro USR_ROTATE_EN adds the rotate control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             enable;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdata;
`ifdef USR_ROTATE_EN
    logic             rotate;
`endif
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

`ifdef USR_ROTATE_EN
    modport master (
        output enable, mode, sin_r, sin_l, pdata, rotate,
        input  q, sout_r, sout_l, shift_cnt, word_done
    );
    modport slave (
        input  enable, mode, sin_r, sin_l, pdata, rotate,
        output q, sout_r, sout_l, shift_cnt, word_done
    );
`else
    modport master (
        output enable, mode, sin_r, sin_l, pdata,
        input  q, sout_r, sout_l, shift_cnt, word_done
    );
    modport slave (
        input  enable, mode, sin_r, sin_l, pdata,
        output q, sout_r, sout_l, shift_cnt, word_done
    );
`endif

endinterface : universal_shift_register_if

`default_nettype wire

// File: rtl/usr_shift_counter.sv
// ============================================================================
// Module      : usr_shift_counter
// Description : Counts shifts within a word. Wraps to zero on the shift that
//               completes WIDTH shifts and raises a registered one-cycle
//               word_done pulse on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_shift_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       inc,
    input  wire logic                       clear,
    output logic [$clog2(WIDTH+1)-1:0]      cnt,
    output logic                            word_done
);
    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_word_done;

    // Counter and word-complete pulse; clear wins over inc, idle drops the pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else if (clear) begin
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else if (inc) begin
            if (r_cnt == c_LAST_CNT) begin
                r_cnt       <= '0;
                r_word_done <= 1'b1;
            end else begin
                r_cnt       <= r_cnt + 1'b1;
                r_word_done <= 1'b0;
            end
        end else begin
            r_word_done <= 1'b0;
        end
    end

    assign cnt       = r_cnt;
    assign word_done = r_word_done;

endmodule : usr_shift_counter

`default_nettype wire

// File: rtl/universal_shift_register.sv
// ============================================================================
// Module      : universal_shift_register
// Description : WIDTH-bit universal shift register: hold, shift right, shift
//               left, parallel load, serial taps at both ends, shift counter
//               with word_done framing pulse.
//               Optional macro USR_ROTATE_EN: rotate input recirculates the
//               outgoing bit instead of taking the serial inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    universal_shift_register_if.slave  bus
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_in_r;
    logic             w_in_l;
    logic             w_shift;
    logic             w_load;

    // Serial bit entering each end; rotation feeds back the departing bit
`ifdef USR_ROTATE_EN
    always_comb begin
        w_in_r = bus.rotate ? r_q[0]       : bus.sin_r;
        w_in_l = bus.rotate ? r_q[WIDTH-1] : bus.sin_l;
    end
`else
    always_comb begin
        w_in_r = bus.sin_r;
        w_in_l = bus.sin_l;
    end
`endif

    // Mode decode and next register value; disabled cycles behave as hold
    always_comb begin
        w_q_next = r_q;
        w_shift  = 1'b0;
        w_load   = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                USR_SHR: begin
                    w_q_next = {w_in_r, r_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                USR_SHL: begin
                    w_q_next = {r_q[WIDTH-2:0], w_in_l};
                    w_shift  = 1'b1;
                end
                USR_LOAD: begin
                    w_q_next = bus.pdata;
                    w_load   = 1'b1;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    // Data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_shift_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (w_shift),
        .clear     (w_load),
        .cnt       (bus.shift_cnt),
        .word_done (bus.word_done)
    );

    // Serial outputs tap the bit that leaves on the next shift
    assign bus.q      = r_q;
    assign bus.sout_r = r_q[0];
    assign bus.sout_l = r_q[WIDTH-1];

endmodule : universal_shift_register

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Directed self-checking bench for universal_shift_register
//               (WIDTH=8). The rotate scenario is built when USR_ROTATE_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_register;
    import usr_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    universal_shift_register_if #(.WIDTH(8)) bus ();

    universal_shift_register #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        bus.enable = 1'b1;
        bus.mode   = USR_LOAD;
        bus.pdata  = d;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_q: got %h expected %h", bus.q, 8'h00);
        end
        checks++;
        if (bus.shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", bus.shift_cnt);
        end
        checks++;
        if (bus.word_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_wd: got %b expected 0", bus.word_done);
        end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_load_hold();
        load(8'h3C);
        checks++;
        if (bus.q !== 8'h3C) begin
            errors++;
            $display("FAIL load_q: got %h expected 3c", bus.q);
        end
        checks++;
        if (bus.sout_r !== 1'b0 || bus.sout_l !== 1'b0) begin
            errors++;
            $display("FAIL load_taps: got r=%b l=%b expected r=0 l=0", bus.sout_r, bus.sout_l);
        end
        bus.mode = USR_HOLD;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.q !== 8'h3C || bus.shift_cnt !== 4'd0 || bus.word_done !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got q=%h cnt=%0d wd=%b expected q=3c cnt=0 wd=0",
                         i, bus.q, bus.shift_cnt, bus.word_done);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_sout;
        int         pulses;
        exp_sout = 8'b1000_0001;   // bit i = expected sout_r before shift i
        pulses   = 0;
        load(8'h81);
        bus.sin_r = 1'b0;
        bus.mode  = USR_SHR;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.sout_r !== exp_sout[i]) begin
                errors++;
                $display("FAIL shr_sout_%0d: got %b expected %b", i, bus.sout_r, exp_sout[i]);
            end
            tick();
            if (bus.word_done === 1'b1) pulses++;
            if (i < 7) begin
                checks++;
                if (bus.word_done !== 1'b0) begin
                    errors++;
                    $display("FAIL shr_early_wd_%0d: got %b expected 0", i, bus.word_done);
                end
            end
        end
        checks++;
        if (bus.q !== 8'h00 || bus.word_done !== 1'b1 || bus.shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL shr_end: got q=%h wd=%b cnt=%0d expected q=00 wd=1 cnt=0",
                     bus.q, bus.word_done, bus.shift_cnt);
        end
        bus.mode = USR_HOLD;
        tick();
        if (bus.word_done === 1'b1) pulses++;
        tick();
        if (bus.word_done === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL shr_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_shift_left();
        bus.sin_l = 1'b1;
        bus.mode  = USR_SHL;
        bus.enable = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.q !== 8'h07 || bus.shift_cnt !== 4'd3) begin
            errors++;
            $display("FAIL shl_q_cnt: got q=%h cnt=%0d expected q=07 cnt=3", bus.q, bus.shift_cnt);
        end
        load(8'h5A);
        checks++;
        if (bus.q !== 8'h5A || bus.shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL shl_load_clear: got q=%h cnt=%0d expected q=5a cnt=0", bus.q, bus.shift_cnt);
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] exp_q;
        int         k;
        load(8'h00);
        bus.sin_r = 1'b1;
        bus.mode  = USR_SHR;
        k = 0;
        for (int e = 0; e < 16; e++) begin
            bus.enable = (e % 2 == 0);
            if (bus.enable) k++;
            tick();
            exp_q = 8'(16'hFF00 >> k);    // k ones filled in from the MSB side
            checks++;
            if (bus.q !== exp_q || bus.shift_cnt !== 4'(k % 8)) begin
                errors++;
                $display("FAIL en_edge_%0d: got q=%h cnt=%0d expected q=%h cnt=%0d",
                         e, bus.q, bus.shift_cnt, exp_q, k % 8);
            end
            checks++;
            if (bus.word_done !== (e == 14)) begin
                errors++;
                $display("FAIL en_wd_%0d: got %b expected %b", e, bus.word_done, (e == 14));
            end
        end
        bus.enable = 1'b1;
        bus.mode   = USR_HOLD;
        tick();
    endtask

    task automatic test_reset_mid();
        load(8'hA5);
        bus.sin_r = 1'b0;
        bus.mode  = USR_SHR;
        tick();
        tick();
        tick();
        checks++;
        if (bus.q !== 8'h14 || bus.shift_cnt !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre: got q=%h cnt=%0d expected q=14 cnt=3", bus.q, bus.shift_cnt);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.q !== 8'h00 || bus.shift_cnt !== 4'd0 || bus.word_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got q=%h cnt=%0d wd=%b expected q=00 cnt=0 wd=0",
                     bus.q, bus.shift_cnt, bus.word_done);
        end
        bus.mode = USR_HOLD;
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.word_done !== 1'b0 || bus.q !== 8'h00) begin
                errors++;
                $display("FAIL mid_after_%0d: got q=%h wd=%b expected q=00 wd=0", i, bus.q, bus.word_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Alternating direction, 16 shifts: counter counts all, two word pulses
        load(8'h00);
        bus.sin_r = 1'b0;
        bus.sin_l = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            bus.mode = (i % 2 == 1) ? USR_SHR : USR_SHL;
            tick();
            checks++;
            if (bus.shift_cnt !== 4'(i % 8) || bus.word_done !== (i == 8 || i == 16)) begin
                errors++;
                $display("FAIL b2b_%0d: got cnt=%0d wd=%b expected cnt=%0d wd=%b",
                         i, bus.shift_cnt, bus.word_done, i % 8, (i == 8 || i == 16));
            end
        end
        bus.mode = USR_HOLD;
        tick();
        checks++;
        if (bus.word_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop: got %b expected 0", bus.word_done);
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        int pulses;
        pulses = 0;
        load(8'h01);
        bus.rotate = 1'b1;
        bus.sin_l  = 1'b0;
        bus.sin_r  = 1'b0;
        bus.mode   = USR_SHL;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.word_done === 1'b1) pulses++;
        end
        checks++;
        if (bus.q !== 8'h01) begin
            errors++;
            $display("FAIL rot_left_q: got %h expected 01", bus.q);
        end
        bus.mode = USR_SHR;
        tick();
        if (bus.word_done === 1'b1) pulses++;
        checks++;
        if (bus.q !== 8'h80) begin
            errors++;
            $display("FAIL rot_right_q: got %h expected 80", bus.q);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL rot_pulses: got %0d expected 1", pulses);
        end
        bus.rotate = 1'b0;
        bus.mode   = USR_HOLD;
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.mode   = USR_HOLD;
        bus.sin_r  = 1'b0;
        bus.sin_l  = 1'b0;
        bus.pdata  = 8'h00;
`ifdef USR_ROTATE_EN
        bus.rotate = 1'b0;
`endif
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_enable_gating();
        test_reset_mid();
        test_back_to_back();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_universal_shift_register

`default_nettype wire
